cache_fill_fsm: RTL and testbench

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

---
 rtl/cache_fill_fsm_pkg.sv | 44 ++++
 rtl/cache_fill_fsm_decoder.sv | 18 +
 rtl/cache_fill_fsm.sv | 152 +++++++++++++++
 tb/tb_cache_fill_fsm.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// Shared cache geometry: address split, metadata layout, fill FSM states.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package cache_fill_fsm_pkg;

    localparam int ADDR_W         = 16;
    localparam int TAG_W          = 6;
    localparam int INDEX_W        = 6;
    localparam int WORD_W         = 3;
    localparam int TAG_LSB        = 10;
    localparam int INDEX_LSB      = 4;
    localparam int WORD_LSB       = 1;
    localparam int DATA_W         = 16;
    localparam int META_W         = 8;
    localparam int META_VALID_BIT = 7;
    localparam int META_LRU_BIT   = 6;
    localparam int WORDS_PER_LINE = 8;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_FILL       = 2'd1,
        ST_META_OTHER = 2'd2
    } fill_state_e;

    // Prefer an invalid way, then the way flagged LRU, falling back to way 0.
    function automatic logic pick_victim(input logic [META_W-1:0] m0,
                                         input logic [META_W-1:0] m1);
        logic way;
        if (!m0[META_VALID_BIT])      way = 1'b0;
        else if (!m1[META_VALID_BIT]) way = 1'b1;
        else if (m0[META_LRU_BIT])    way = 1'b0;
        else if (m1[META_LRU_BIT])    way = 1'b1;
        else                          way = 1'b0;
        return way;
    endfunction

    function automatic logic [META_W-1:0] make_meta(input logic             valid,
                                                    input logic             lru,
                                                    input logic [TAG_W-1:0] tag);
        return {valid, lru, tag};
    endfunction

endpackage

// File: rtl/cache_fill_fsm_decoder.sv
// One-hot 6-to-64 decoder with enable; all-zero when disabled.
// Latency: combinational.
// Backpressure: none.
module onehot_decoder_6to64 (
    input  logic        en,
    input  logic [5:0]  idx,
    output logic [63:0] onehot
);

    // Single set bit selected by idx while enabled.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Two-way cache line fill: pick victim, fetch 8 words, write data, then update both ways' metadata.
// Latency: requests start the cycle after a miss is accepted; writes follow each memory_data_valid combinationally.
// Backpressure: none toward memory; misses are ignored while a fill is in progress.
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
#(
    parameter int MEM_LATENCY = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               miss_detected,
    input  logic [ADDR_W-1:0]  miss_address,
    input  logic [META_W-1:0]  meta_in0,
    input  logic [META_W-1:0]  meta_in1,
    input  logic [DATA_W-1:0]  memory_data,
    input  logic               memory_data_valid,
    output logic               fsm_busy,
    output logic [ADDR_W-1:0]  memory_address,
    output logic               memory_read,
    output logic [63:0]        set_enable,
    output logic [7:0]         word_enable,
    output logic               data_write0,
    output logic               data_write1,
    output logic [DATA_W-1:0]  data_out,
    output logic               meta_write0,
    output logic               meta_write1,
    output logic [META_W-1:0]  meta_out
);

    fill_state_e        state_q, state_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]   recv_cnt_q, recv_cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic               victim_q, victim_d;
    logic [META_W-1:0]  other_meta_q, other_meta_d;
    logic               set_en;

    // Memory timing is carried entirely by the valid strobe; the latency
    // parameter and the in-line word offset of the miss do not steer the fill.
    logic [31:0] unused_latency;
    logic        unused_bits;
    assign unused_latency = MEM_LATENCY;
    assign unused_bits    = ^{miss_address[WORD_LSB +: WORD_W], miss_address[0],
                              other_meta_q[META_LRU_BIT]};

    // Next-state, counter, latch and output decode for the fill sequence.
    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        tag_d        = tag_q;
        index_d      = index_q;
        victim_d     = victim_q;
        other_meta_d = other_meta_q;

        fsm_busy       = 1'b0;
        memory_address = '0;
        memory_read    = 1'b0;
        set_en         = 1'b0;
        word_enable    = '0;
        data_write0    = 1'b0;
        data_write1    = 1'b0;
        data_out       = '0;
        meta_write0    = 1'b0;
        meta_write1    = 1'b0;
        meta_out       = '0;

        case (state_q)
            ST_IDLE: begin
                // Busy is reported in the accept cycle itself; gated so reset drives it low.
                fsm_busy = miss_detected & rst;
                if (miss_detected) begin
                    tag_d        = miss_address[TAG_LSB +: TAG_W];
                    index_d      = miss_address[INDEX_LSB +: INDEX_W];
                    victim_d     = pick_victim(meta_in0, meta_in1);
                    other_meta_d = pick_victim(meta_in0, meta_in1) ? meta_in0 : meta_in1;
                    issue_cnt_d  = '0;
                    recv_cnt_d   = '0;
                    state_d      = ST_FILL;
                end
            end

            ST_FILL: begin
                fsm_busy = 1'b1;
                set_en   = 1'b1;
                if (issue_cnt_q < CNT_W'(WORDS_PER_LINE)) begin
                    memory_read    = 1'b1;
                    memory_address = {tag_q, index_q, issue_cnt_q[WORD_W-1:0], 1'b0};
                    issue_cnt_d    = issue_cnt_q + CNT_W'(1);
                end
                if (memory_data_valid && (recv_cnt_q < CNT_W'(WORDS_PER_LINE))) begin
                    data_out                             = memory_data;
                    word_enable[recv_cnt_q[WORD_W-1:0]] = 1'b1;
                    data_write0                          = ~victim_q;
                    data_write1                          = victim_q;
                    recv_cnt_d                           = recv_cnt_q + CNT_W'(1);
                    // Last word of the line: mark the victim valid and most recently used.
                    if (recv_cnt_q == CNT_W'(WORDS_PER_LINE - 1)) begin
                        meta_write0 = ~victim_q;
                        meta_write1 = victim_q;
                        meta_out    = make_meta(1'b1, 1'b0, tag_q);
                        state_d     = ST_META_OTHER;
                    end
                end
            end

            ST_META_OTHER: begin
                // The non-victim way becomes LRU, keeping its valid bit and tag from the miss.
                fsm_busy    = 1'b1;
                set_en      = 1'b1;
                meta_write0 = victim_q;
                meta_write1 = ~victim_q;
                meta_out    = make_meta(other_meta_q[META_VALID_BIT], 1'b1,
                                        other_meta_q[TAG_W-1:0]);
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and miss latches; asynchronous reset aborts any fill in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            tag_q        <= '0;
            index_q      <= '0;
            victim_q     <= 1'b0;
            other_meta_q <= '0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            recv_cnt_q   <= recv_cnt_d;
            tag_q        <= tag_d;
            index_q      <= index_d;
            victim_q     <= victim_d;
            other_meta_q <= other_meta_d;
        end
    end

    onehot_decoder_6to64 u_set_dec (
        .en     (set_en),
        .idx    (index_q),
        .onehot (set_enable)
    );

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a memory responder and write scoreboard.
// Latency: inputs driven at negedge, outputs sampled 1 time unit later.
// Backpressure: n/a.
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [7:0]  meta_in0;
    logic [7:0]  meta_in1;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic [15:0] memory_address;
    logic        memory_read;
    logic [63:0] set_enable;
    logic [7:0]  word_enable;
    logic        data_write0;
    logic        data_write1;
    logic [15:0] data_out;
    logic        meta_write0;
    logic        meta_write1;
    logic [7:0]  meta_out;

    cache_fill_fsm #(.MEM_LATENCY(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .meta_in0          (meta_in0),
        .meta_in1          (meta_in1),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .memory_address    (memory_address),
        .memory_read       (memory_read),
        .set_enable        (set_enable),
        .word_enable       (word_enable),
        .data_write0       (data_write0),
        .data_write1       (data_write1),
        .data_out          (data_out),
        .meta_write0       (meta_write0),
        .meta_write1       (meta_write1),
        .meta_out          (meta_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int due; logic [15:0] dat; } ret_t;
    typedef struct { logic [7:0] we; logic [15:0] dat; logic way; } wr_t;
    typedef struct { logic way; logic [7:0] b; } mt_t;

    ret_t ret_q[$];
    wr_t  wr_q[$];
    mt_t  mt_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic        miss_cmd = 1'b0;
    logic [15:0] addr_cmd = '0;
    logic [7:0]  m0_cmd   = '0;
    logic [7:0]  m1_cmd   = '0;
    bit          stray    = 1'b0;
    bit          bursty   = 1'b0;

    logic [5:0] e_tag;
    logic [5:0] e_idx;
    logic       e_way;
    int req_n, wr_n, meta_n, last_due, victim_meta_cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0] ^ 8'h3C, a[15:8] ^ 8'hA5};
    endfunction

    // Queue the expected metadata writes for a miss and present it to the DUT.
    task automatic start_miss(input logic [15:0] a, input logic [7:0] m0, input logic [7:0] m1);
        mt_t m;
        logic [7:0] oth;
        e_tag = a[15:10];
        e_idx = a[9:4];
        if (!m0[7])      e_way = 1'b0;
        else if (!m1[7]) e_way = 1'b1;
        else if (m0[6])  e_way = 1'b0;
        else if (m1[6])  e_way = 1'b1;
        else             e_way = 1'b0;
        oth   = e_way ? m0 : m1;
        m.way = e_way;
        m.b   = {2'b10, e_tag};
        mt_q.push_back(m);
        m.way = ~e_way;
        m.b   = {oth[7], 1'b1, oth[5:0]};
        mt_q.push_back(m);
        req_n    = 0;
        wr_n     = 0;
        meta_n   = 0;
        last_due = 0;
        miss_cmd = 1'b1;
        addr_cmd = a;
        m0_cmd   = m0;
        m1_cmd   = m1;
    endtask

    // One clock: drive inputs and memory response, then score the outputs.
    task automatic step();
        ret_t r;
        wr_t  w;
        mt_t  m;
        int   d;
        logic [15:0] ea;
        @(negedge clk);
        cyc++;
        miss_detected = miss_cmd;
        miss_address  = addr_cmd;
        meta_in0      = m0_cmd;
        meta_in1      = m1_cmd;
        if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            r = ret_q.pop_front();
            memory_data_valid = 1'b1;
            memory_data       = r.dat;
        end else begin
            memory_data_valid = stray;
            memory_data       = stray ? 16'hDEAD : 16'h0000;
        end
        #1;
        if (data_write0 || data_write1) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write", {data_write1, data_write0}, 0);
            end else begin
                w = wr_q.pop_front();
                check("data_write_way", {data_write1, data_write0}, w.way ? 2'b10 : 2'b01);
                check("word_enable", word_enable, w.we);
                check("data_out", data_out, w.dat);
                wr_n++;
            end
        end
        if (meta_write0 || meta_write1) begin
            if (mt_q.size() == 0) begin
                check("unexpected_meta", {meta_write1, meta_write0}, 0);
            end else begin
                m = mt_q.pop_front();
                check("meta_way", {meta_write1, meta_write0}, m.way ? 2'b10 : 2'b01);
                check("meta_out", meta_out, m.b);
                if (meta_n == 0) begin
                    check("meta_with_8th_write", wr_n, 8);
                    check("meta_same_cycle_write", data_write0 | data_write1, 1);
                    victim_meta_cyc = cyc;
                end else begin
                    check("meta_other_next_cycle", cyc, victim_meta_cyc + 1);
                end
                check("set_en_meta", set_enable, 64'd1 << e_idx);
                meta_n++;
            end
        end
        if (memory_read) begin
            ea = {e_tag, e_idx, 3'(req_n), 1'b0};
            check("mem_addr", memory_address, ea);
            check("req_within_line", req_n < 8, 1);
            check("set_en_fill", set_enable, 64'd1 << e_idx);
            if (bursty) begin
                d = last_due + 1 + int'($urandom_range(3, 0));
                if (d < cyc + 1) d = cyc + 1;
            end else begin
                d = cyc + 4;
            end
            last_due = d;
            r.due = d;
            r.dat = mem_word(ea);
            ret_q.push_back(r);
            w.we  = 8'd1 << req_n[2:0];
            w.dat = r.dat;
            w.way = e_way;
            wr_q.push_back(w);
            req_n++;
        end
        if (stray) begin
            check("stray_no_strobe", {data_write0, data_write1, meta_write0, meta_write1}, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {fsm_busy, memory_address, memory_read, word_enable, data_write0,
                    data_write1, data_out, meta_write0, meta_write1, meta_out}, 0);
        check({tag, "_set_en"}, set_enable, 0);
    endtask

    task automatic fill_loop(input int limit);
        for (int i = 0; i < limit && meta_n < 2; i++) step();
        check("fill_completed", meta_n, 2);
        check("eight_requests", req_n, 8);
        check("eight_writes", wr_n, 8);
    endtask

    task automatic run_fill(input int limit);
        fill_loop(limit);
        step();
        check("idle_after_fill", {fsm_busy, memory_read}, 0);
        check("idle_set_en", set_enable, 0);
    endtask

    task automatic accept_step();
        step();
        check("accept_busy", fsm_busy, 1);
        check("accept_no_read", memory_read, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst               = 1'b0;
        miss_detected     = 1'b0;
        miss_address      = '0;
        meta_in0          = '0;
        meta_in1          = '0;
        memory_data       = '0;
        memory_data_valid = 1'b0;

        // Reset state, including a miss held during reset.
        miss_cmd = 1'b1;
        step();
        check_all_zero("reset_state_miss_high");
        miss_cmd = 1'b0;
        step();
        check_all_zero("reset_state");
        rst = 1'b1;
        step();
        check_all_zero("idle_after_reset");

        // Way-0 invalid fill, fixed 4-cycle latency.
        start_miss(16'h1A34, 8'h00, 8'h00);
        accept_step();
        miss_cmd = 1'b0;
        step();
        check("first_fill_read", memory_read, 1);
        check("set_bit35", set_enable, 64'h0000_0008_0000_0000);
        run_fill(60);

        // LRU eviction to way 1.
        start_miss(16'h4C7E, 8'h85, 8'hC3);
        accept_step();
        miss_cmd = 1'b0;
        run_fill(60);

        // Bursty memory returns.
        bursty = 1'b1;
        start_miss(16'hFFFE, 8'h80, 8'h00);
        accept_step();
        miss_cmd = 1'b0;
        run_fill(200);
        start_miss(16'h0C50, 8'hA1, 8'hB2);
        accept_step();
        miss_cmd = 1'b0;
        run_fill(200);
        bursty = 1'b0;

        // Miss held high through a fill with changing address and metadata.
        start_miss(16'h1234, 8'h00, 8'h80);
        accept_step();
        addr_cmd = 16'h8F00;
        m0_cmd   = 8'hC1;
        m1_cmd   = 8'h82;
        fill_loop(60);
        start_miss(16'h8F00, 8'hC1, 8'h82);
        accept_step();
        miss_cmd = 1'b0;
        step();
        check("second_fill_start", memory_read, 1);
        run_fill(60);

        // Reset at the 5th received word.
        start_miss(16'h2468, 8'h80, 8'h80);
        accept_step();
        miss_cmd = 1'b0;
        for (int i = 0; i < 40 && wr_n < 5; i++) step();
        check("reached_5th_word", wr_n, 5);
        rst = 1'b0;
        #1;
        check_all_zero("rst_mid_fill");
        ret_q.delete();
        wr_q.delete();
        mt_q.delete();
        stray = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all_zero("rst_hold");
        end
        stray = 1'b0;
        rst = 1'b1;
        step();
        check_all_zero("idle_after_abort");
        start_miss(16'h2468, 8'h80, 8'h80);
        accept_step();
        miss_cmd = 1'b0;
        run_fill(60);

        // Stray data-valid strobes in IDLE.
        stray = 1'b1;
        for (int i = 0; i < 3; i++) step();
        stray = 1'b0;
        step();
        check_all_zero("idle_after_stray");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
